// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl
//   Frame sequencer in front of the Gaussian/Sobel/gradient filter chain.
//   Validates and latches the per-frame configuration on start, pulses
//   f_new_frame, gates source beats into the filter with a valid/ready
//   handshake, counts beats in and out, and reports completion and errors.
//
//   Optional build macro: FRAME_TIMEOUT_EN
//     defined   -> drain watchdog: TIMEOUT consecutive DRAIN cycles without an
//                  f_out_vld abort the frame (err_timeout pulse, no frame_cnt++)
//     undefined -> no watchdog, err_timeout is constant 0, DRAIN waits forever
//
// Ports
//   sys_clk, sys_rst_n          clock, async active-low reset
//   start                       single-cycle frame request (honoured in IDLE only)
//   cfg_rows/cfg_cols/cfg_bypass frame configuration, sampled on accepted start
//   s_data, s_vld, s_rdy        source beat handshake (s_rdy high in ACTIVE)
//   f_rows/f_cols/f_bypass      latched configuration to the filter
//   f_new_frame                 one-cycle frame-start pulse
//   f_data, f_vld               registered copy of each accepted beat
//   f_out_vld                   filter output-beat strobe
//   busy                        state != IDLE
//   frame_done                  one-cycle completion pulse
//   err_cfg                     one-cycle pulse, cycle after a rejected start
//   err_timeout                 one-cycle pulse on drain watchdog expiry
//   frame_cnt                   completed frames, free-running 16 bit
module filter_frame_ctrl #(
   parameter int DWIDTH  = 10,
   parameter int PIXCNT  = 8,
   parameter int ROWS    = 2048,
   parameter int COLS    = 2448,
   parameter int TIMEOUT = 4096
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic                        start,
   input  logic [$clog2(ROWS)-1:0]     cfg_rows,
   input  logic [$clog2(COLS)-1:0]     cfg_cols,
   input  logic [1:0]                  cfg_bypass,
   input  logic [DWIDTH*PIXCNT-1:0]    s_data,
   input  logic                        s_vld,
   output logic                        s_rdy,
   output logic [$clog2(ROWS)-1:0]     f_rows,
   output logic [$clog2(COLS)-1:0]     f_cols,
   output logic [1:0]                  f_bypass,
   output logic                        f_new_frame,
   output logic [DWIDTH*PIXCNT-1:0]    f_data,
   output logic                        f_vld,
   input  logic                        f_out_vld,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        err_cfg,
   output logic                        err_timeout,
   output logic [15:0]                 frame_cnt
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int TW = RW + CW;   // rows*bpr always fits, no overflow
   localparam logic [CW-1:0] PIX_C = CW'(PIXCNT);

   typedef enum logic [2:0] {IDLE, START, ACTIVE, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] bpr, bpr_nxt;
   logic [TW-1:0] total, total_nxt, out_cnt;
   logic [RW-1:0] row_cnt;
   logic [CW-1:0] col_beat;
   logic          cfg_ok, cfg_take, accept, last_beat, out_done, out_hit;
   logic          tmo_fire, tmo_err, err_cfg_q;

   assign cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && ((cfg_cols % PIX_C) == '0);
   assign cfg_take  = (state == IDLE) && start && cfg_ok;
   assign bpr_nxt   = cfg_cols / PIX_C;
   assign total_nxt = TW'(cfg_rows) * TW'(bpr_nxt);

   assign accept    = (state == ACTIVE) && s_vld;
   assign last_beat = (row_cnt == f_rows - 1'b1) && (col_beat == bpr - 1'b1);
   assign out_done  = (out_cnt == total);
   // Output strobes count only while a frame is streaming or draining, and
   // never past total so a chatty filter cannot skip the completion compare.
   assign out_hit   = f_out_vld && ((state == ACTIVE) || (state == DRAIN)) && !out_done;

`ifdef FRAME_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wd_cnt;

   // Counts consecutive DRAIN cycles without an output beat.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         wd_cnt <= '0;
      else if ((state != DRAIN) || f_out_vld)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end

   assign tmo_fire = (state == DRAIN) && !f_out_vld && (wd_cnt == WW'(TIMEOUT - 1));
`else
   assign tmo_fire = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      tmo_err     = 1'b0;
      s_rdy       = (state == ACTIVE);
      f_new_frame = (state == START);
      frame_done  = (state == DONE);
      busy        = (state != IDLE);
      unique case (state)
         IDLE:    if (cfg_take) state_nxt = START;
         START:   state_nxt = ACTIVE;
         ACTIVE:  if (accept && last_beat) state_nxt = DRAIN;
         DRAIN: begin
            // completion wins over a watchdog expiring on the same cycle
            if (out_done) begin
               state_nxt = DONE;
            end else if (tmo_fire) begin
               state_nxt = IDLE;
               tmo_err   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign err_timeout = tmo_err;
   assign err_cfg     = err_cfg_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         f_rows    <= '0;
         f_cols    <= '0;
         f_bypass  <= '0;
         bpr       <= '0;
         total     <= '0;
         row_cnt   <= '0;
         col_beat  <= '0;
         out_cnt   <= '0;
         f_data    <= '0;
         f_vld     <= 1'b0;
         err_cfg_q <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         err_cfg_q <= (state == IDLE) && start && !cfg_ok;
         f_vld     <= accept;
         if (accept)
            f_data <= s_data;

         if (cfg_take) begin
            f_rows   <= cfg_rows;
            f_cols   <= cfg_cols;
            f_bypass <= cfg_bypass;
            bpr      <= bpr_nxt;
            total    <= total_nxt;
            row_cnt  <= '0;
            col_beat <= '0;
            out_cnt  <= '0;
         end

         if (accept) begin
            if (col_beat == bpr - 1'b1) begin
               col_beat <= '0;
               row_cnt  <= row_cnt + 1'b1;
            end else begin
               col_beat <= col_beat + 1'b1;
            end
         end

         if (out_hit)
            out_cnt <= out_cnt + 1'b1;

         if (state == DONE)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule
